// File: rtl/clock_divider_prog_if.sv
// Divisor load channel for clock_divider_prog: valid/ready handshake carrying
// a new half-period-minus-one value. The source drives the master modport and
// the divider is the slave.
interface clock_divider_prog_if #(
  parameter int unsigned CNT_W = 16
);
  logic [CNT_W-1:0] div_in;
  logic             div_load_valid;
  logic             div_load_ready;

  modport master (
    output div_in,
    output div_load_valid,
    input  div_load_ready
  );

  modport slave (
    input  div_in,
    input  div_load_valid,
    output div_load_ready
  );
endinterface

// File: rtl/clock_divider_prog.sv
// Runtime-programmable 50%-duty clock divider with registered rise/fall strobes.
// A new divisor is accepted into a single pending slot through the load
// interface and swapped in at the next terminal count, so every half-period
// is a whole one and no runt pulse can appear on reprogramming.
// Optional: define CLOCK_DIVIDER_PHASE_SYNC_EN to add the phase_sync input,
// which restarts the output low at counter 0 without touching the divisor.
module clock_divider_prog #(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned DEFAULT_DIV = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  clock_divider_prog_if.slave  load,
`ifdef CLOCK_DIVIDER_PHASE_SYNC_EN
  input  logic                 phase_sync,
`endif
  output logic                 divided_clk,
  output logic                 rise_tick,
  output logic                 fall_tick,
  output logic [CNT_W-1:0]     div_active
);

  localparam logic [CNT_W-1:0] LP_DEFAULT_DIV = CNT_W'(DEFAULT_DIV);

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_e;

  slot_e            r_slot, w_slot_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [CNT_W-1:0] r_div_active, w_div_active_nxt;
  logic [CNT_W-1:0] r_pending, w_pending_nxt;
  logic             r_clk, w_clk_nxt;
  logic             r_rise, w_rise_nxt;
  logic             r_fall, w_fall_nxt;
  logic             w_sync;
  logic             w_tc;
  logic             w_accept;

`ifdef CLOCK_DIVIDER_PHASE_SYNC_EN
  assign w_sync = phase_sync;
`else
  assign w_sync = 1'b0;
`endif

  assign w_tc     = en && (r_cnt == r_div_active);
  assign w_accept = load.div_load_valid && (r_slot == SLOT_EMPTY);

  // State register: counter, output level, strobes, divisor and pending slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt        <= '0;
      r_clk        <= 1'b0;
      r_rise       <= 1'b0;
      r_fall       <= 1'b0;
      r_div_active <= LP_DEFAULT_DIV;
      r_pending    <= '0;
      r_slot       <= SLOT_EMPTY;
    end else begin
      r_cnt        <= w_cnt_nxt;
      r_clk        <= w_clk_nxt;
      r_rise       <= w_rise_nxt;
      r_fall       <= w_fall_nxt;
      r_div_active <= w_div_active_nxt;
      r_pending    <= w_pending_nxt;
      r_slot       <= w_slot_nxt;
    end
  end

  // Next state: phase sync beats terminal count beats plain counting; the
  // pending divisor is applied only at a terminal count (counter returns to 0),
  // and a load can only be taken while the slot is empty, so apply and accept
  // never collide and a load on a TC cycle waits for the following TC.
  always_comb begin
    w_cnt_nxt        = r_cnt;
    w_clk_nxt        = r_clk;
    w_rise_nxt       = 1'b0;
    w_fall_nxt       = 1'b0;
    w_div_active_nxt = r_div_active;
    w_pending_nxt    = r_pending;
    w_slot_nxt       = r_slot;

    if (w_sync) begin
      w_cnt_nxt = '0;
      w_clk_nxt = 1'b0;
    end else if (w_tc) begin
      w_cnt_nxt  = '0;
      w_clk_nxt  = ~r_clk;
      w_rise_nxt = ~r_clk;
      w_fall_nxt = r_clk;
      if (r_slot == SLOT_FULL) begin
        w_div_active_nxt = r_pending;
        w_slot_nxt       = SLOT_EMPTY;
      end
    end else if (en) begin
      w_cnt_nxt = r_cnt + 1'b1;
    end

    if (w_accept) begin
      w_pending_nxt = load.div_in;
      w_slot_nxt    = SLOT_FULL;
    end
  end

  assign load.div_load_ready = (r_slot == SLOT_EMPTY);
  assign divided_clk         = r_clk;
  assign rise_tick           = r_rise;
  assign fall_tick           = r_fall;
  assign div_active          = r_div_active;

endmodule

// File: tb/tb_clock_divider_prog.sv
// Directed testbench for clock_divider_prog (CNT_W=16, DEFAULT_DIV=1).
// Inputs change 1 time unit after each rising edge; outputs are sampled there.
module tb_clock_divider_prog;

  logic clk = 1'b0;
  logic rst;
  logic en;
  logic ps_main;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  clock_divider_prog_if #(.CNT_W(16)) bus ();

  logic        dclk, rise, fall;
  logic [15:0] dact;

  clock_divider_prog #(.CNT_W(16), .DEFAULT_DIV(1)) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .load        (bus.slave),
`ifdef CLOCK_DIVIDER_PHASE_SYNC_EN
    .phase_sync  (ps_main),
`endif
    .divided_clk (dclk),
    .rise_tick   (rise),
    .fall_tick   (fall),
    .div_active  (dact)
  );

`ifdef CLOCK_DIVIDER_PHASE_SYNC_EN
  logic        rst_a, rst_b, ps;
  logic        clk_a, rise_a, fall_a, clk_b, rise_b, fall_b;
  logic [15:0] dact_a, dact_b;
  clock_divider_prog_if #(.CNT_W(16)) bus_a ();
  clock_divider_prog_if #(.CNT_W(16)) bus_b ();

  clock_divider_prog #(.CNT_W(16), .DEFAULT_DIV(2)) dut_a (
    .clk(clk), .rst(rst_a), .en(en), .load(bus_a.slave), .phase_sync(ps),
    .divided_clk(clk_a), .rise_tick(rise_a), .fall_tick(fall_a), .div_active(dact_a)
  );
  clock_divider_prog #(.CNT_W(16), .DEFAULT_DIV(2)) dut_b (
    .clk(clk), .rst(rst_b), .en(en), .load(bus_b.slave), .phase_sync(ps),
    .divided_clk(clk_b), .rise_tick(rise_b), .fall_tick(fall_b), .div_active(dact_b)
  );
`endif

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reset state, then 16 enabled cycles at DEFAULT_DIV=1 (period 4).
  task automatic test_reset();
    logic [2:0] exp_v;
    rst = 1'b1; en = 1'b1; ps_main = 1'b0;
    bus.div_load_valid = 1'b0; bus.div_in = '0;
    step(); step();
    checks++;
    if ({dclk, rise, fall, bus.div_load_ready} !== 4'b0001) begin
      failures++;
      $display("FAIL reset_outputs got clk/rise/fall/ready=%b expected 0001",
               {dclk, rise, fall, bus.div_load_ready});
    end
    checks++;
    if (dact !== 16'd1) begin
      failures++;
      $display("FAIL reset_div_active got %0d expected 1", dact);
    end
    rst = 1'b0;
    for (int n = 1; n <= 16; n++) begin
      step();
      exp_v = {(n % 4 == 2) || (n % 4 == 3), n % 4 == 2, n % 4 == 0};
      checks++;
      if ({dclk, rise, fall} !== exp_v) begin
        failures++;
        $display("FAIL reset_run_cycle%0d got clk/rise/fall=%b expected %b", n, {dclk, rise, fall}, exp_v);
      end
    end
    checks++;
    if (dact !== 16'd1) begin
      failures++;
      $display("FAIL reset_run_div_active got %0d expected 1", dact);
    end
  endtask

  // Load 3 with counter at 0 of a low half-period (div 1): current half
  // completes after 2 cycles, then half-periods of 4.
  task automatic test_load_mid();
    logic [2:0] exp_v;
    int m;
    bus.div_in = 16'd3; bus.div_load_valid = 1'b1;
    step();
    bus.div_load_valid = 1'b0;
    checks++;
    if ({bus.div_load_ready, dclk} !== 2'b00 || dact !== 16'd1) begin
      failures++;
      $display("FAIL load_mid_accept got ready/clk=%b div=%0d expected 00 div=1", {bus.div_load_ready, dclk}, dact);
    end
    step();
    checks++;
    if ({dclk, rise, fall, bus.div_load_ready} !== 4'b1101 || dact !== 16'd3) begin
      failures++;
      $display("FAIL load_mid_apply got clk/rise/fall/ready=%b div=%0d expected 1101 div=3",
               {dclk, rise, fall, bus.div_load_ready}, dact);
    end
    for (int k = 1; k <= 8; k++) begin
      step();
      m = k % 8;
      exp_v = {m < 4, m == 0, m == 4};
      checks++;
      if ({dclk, rise, fall} !== exp_v || dact !== 16'd3) begin
        failures++;
        $display("FAIL load_mid_cycle%0d got clk/rise/fall=%b div=%0d expected %b div=3",
                 k, {dclk, rise, fall}, dact, exp_v);
      end
    end
  endtask

  // Return to div 1, then present div 0 exactly on a TC cycle and a second
  // load (5) while ready is low.
  task automatic test_load_on_tc();
    bus.div_in = 16'd1; bus.div_load_valid = 1'b1;
    step();
    bus.div_load_valid = 1'b0;
    step(); step(); step();
    checks++;
    if ({dclk, fall, bus.div_load_ready} !== 3'b011 || dact !== 16'd1) begin
      failures++;
      $display("FAIL tc_setup got clk/fall/ready=%b div=%0d expected 011 div=1", {dclk, fall, bus.div_load_ready}, dact);
    end
    step();
    bus.div_in = 16'd0; bus.div_load_valid = 1'b1;
    step();
    checks++;
    if ({dclk, rise, bus.div_load_ready} !== 3'b110 || dact !== 16'd1) begin
      failures++;
      $display("FAIL tc_accept got clk/rise/ready=%b div=%0d expected 110 div=1", {dclk, rise, bus.div_load_ready}, dact);
    end
    bus.div_in = 16'd5;
    step();
    checks++;
    if ({dclk, rise, fall, bus.div_load_ready} !== 4'b1000) begin
      failures++;
      $display("FAIL tc_hold got clk/rise/fall/ready=%b expected 1000", {dclk, rise, fall, bus.div_load_ready});
    end
    step();
    bus.div_load_valid = 1'b0;
    checks++;
    if ({dclk, fall, bus.div_load_ready} !== 3'b011 || dact !== 16'd0) begin
      failures++;
      $display("FAIL tc_apply got clk/fall/ready=%b div=%0d expected 011 div=0", {dclk, fall, bus.div_load_ready}, dact);
    end
    for (int k = 1; k <= 4; k++) begin
      step();
      checks++;
      if ({dclk, rise, fall} !== {k % 2 == 1, k % 2 == 1, k % 2 == 0} || dact !== 16'd0) begin
        failures++;
        $display("FAIL tc_period2_cycle%0d got clk/rise/fall=%b div=%0d expected %b div=0",
                 k, {dclk, rise, fall}, dact, {k % 2 == 1, k % 2 == 1, k % 2 == 0});
      end
    end
  endtask

  // div 0 with en sequence 1,1,0,0,1.
  task automatic test_enable();
    logic       en_seq [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [2:0] exp_seq[5] = '{3'b110, 3'b001, 3'b000, 3'b000, 3'b110};
    for (int i = 0; i < 5; i++) begin
      en = en_seq[i];
      step();
      checks++;
      if ({dclk, rise, fall} !== exp_seq[i]) begin
        failures++;
        $display("FAIL enable_step%0d got clk/rise/fall=%b expected %b", i, {dclk, rise, fall}, exp_seq[i]);
      end
    end
    en = 1'b1;
  endtask

  // Accept a load with en=0 while output is high, then reset.
  task automatic test_reset_pending();
    logic [2:0] exp_v;
    en = 1'b0; bus.div_in = 16'd7; bus.div_load_valid = 1'b1;
    step();
    bus.div_load_valid = 1'b0;
    checks++;
    if ({dclk, bus.div_load_ready} !== 2'b10 || dact !== 16'd0) begin
      failures++;
      $display("FAIL rstpend_accept got clk/ready=%b div=%0d expected 10 div=0", {dclk, bus.div_load_ready}, dact);
    end
    rst = 1'b1; en = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if ({dclk, rise, fall, bus.div_load_ready} !== 4'b0001 || dact !== 16'd1) begin
      failures++;
      $display("FAIL rstpend_reset got clk/rise/fall/ready=%b div=%0d expected 0001 div=1",
               {dclk, rise, fall, bus.div_load_ready}, dact);
    end
    for (int n = 1; n <= 8; n++) begin
      step();
      exp_v = {(n % 4 == 2) || (n % 4 == 3), n % 4 == 2, n % 4 == 0};
      checks++;
      if ({dclk, rise, fall} !== exp_v || dact !== 16'd1) begin
        failures++;
        $display("FAIL rstpend_cycle%0d got clk/rise/fall=%b div=%0d expected %b div=1",
                 n, {dclk, rise, fall}, dact, exp_v);
      end
    end
  endtask

`ifdef CLOCK_DIVIDER_PHASE_SYNC_EN
  // Two div-2 instances released one cycle apart, then phase-synced together.
  task automatic test_phase_sync();
    logic [2:0] exp_v;
    int m;
    bus_a.div_load_valid = 1'b0; bus_a.div_in = '0;
    bus_b.div_load_valid = 1'b0; bus_b.div_in = '0;
    ps = 1'b0; en = 1'b1;
    rst_a = 1'b0;
    step();
    rst_b = 1'b0;
    for (int i = 0; i < 4; i++) step();
    ps = 1'b1;
    step();
    ps = 1'b0;
    checks++;
    if ({clk_a, rise_a, fall_a, clk_b, rise_b, fall_b} !== 6'b0) begin
      failures++;
      $display("FAIL psync_pulse got a=%b b=%b expected 000 000", {clk_a, rise_a, fall_a}, {clk_b, rise_b, fall_b});
    end
    for (int k = 1; k <= 12; k++) begin
      step();
      m = k % 6;
      exp_v = {m >= 3, m == 3, m == 0};
      checks++;
      if ({clk_a, rise_a, fall_a} !== exp_v || {clk_b, rise_b, fall_b} !== exp_v) begin
        failures++;
        $display("FAIL psync_cycle%0d got a=%b b=%b expected %b", k, {clk_a, rise_a, fall_a}, {clk_b, rise_b, fall_b}, exp_v);
      end
    end
  endtask
`endif

  initial begin
`ifdef CLOCK_DIVIDER_PHASE_SYNC_EN
    rst_a = 1'b1; rst_b = 1'b1; ps = 1'b0;
`endif
    test_reset();
    test_load_mid();
    test_load_on_tc();
    test_enable();
    test_reset_pending();
`ifdef CLOCK_DIVIDER_PHASE_SYNC_EN
    test_phase_sync();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
